// File: rtl/hsv_led_sequencer.sv
// ============================================================================
//  Module      : hsv_led_sequencer
//  Description : Shares one external combinational hsv2rgb converter across
//                NUM_LEDS channels. A prescaler advances a global base hue;
//                each tick launches a frame that walks every LED at
//                hue = base_hue + idx*spread and emits the converted RGB on a
//                valid-strobed bus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsv_led_sequencer #(
   parameter int NUM_LEDS = 4,
   parameter int IDX_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             cfg_we,
   input  logic [1:0]       cfg_addr,
   input  logic [7:0]       cfg_wdata,
   output logic [7:0]       hsv_h,
   output logic [7:0]       hsv_s,
   output logic [7:0]       hsv_v,
   input  logic [7:0]       rgb_r,
   input  logic [7:0]       rgb_g,
   input  logic [7:0]       rgb_b,
   output logic [IDX_W-1:0] led_idx,
   output logic [23:0]      led_rgb,
   output logic             led_valid,
   output logic             frame_done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CAPT = 2'd2;

   localparam logic [1:0] ADDR_SAT    = 2'd0;
   localparam logic [1:0] ADDR_VAL    = 2'd1;
   localparam logic [1:0] ADDR_SPEED  = 2'd2;
   localparam logic [1:0] ADDR_SPREAD = 2'd3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

   // MCU-visible configuration
   logic [7:0]       sat;
   logic [7:0]       val;
   logic [7:0]       speed;
   logic [7:0]       spread;

   // Per-frame working copies, frozen at frame start
   logic [7:0]       sat_sh;
   logic [7:0]       val_sh;
   logic [7:0]       spread_sh;

   logic [15:0]      presc;
   logic [7:0]       base_hue;
   logic             pending;
   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [7:0]       hue_acc;

   logic             tick;
   logic             start;
   logic             speed_wr;

   // Prescaler terminal count is (speed+1)*256-1 = {speed, FF}
   assign tick     = enable && (presc == {speed, 8'hFF});
   assign start    = (state == S_IDLE) && (pending || tick);
   assign speed_wr = cfg_we && (cfg_addr == ADDR_SPEED);

   // Configuration register writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat    <= 8'hFF;
         val    <= 8'hFF;
         speed  <= 8'h00;
         spread <= 8'h40;
      end else if (cfg_we) begin
         case (cfg_addr)
            ADDR_SAT:    sat    <= cfg_wdata;
            ADDR_VAL:    val    <= cfg_wdata;
            ADDR_SPEED:  speed  <= cfg_wdata;
            ADDR_SPREAD: spread <= cfg_wdata;
            default:     ;
         endcase
      end
   end

   // Prescaler: holds while disabled, restarts on a speed write
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= 16'd0;
      end else if (speed_wr) begin
         presc <= 16'd0;
      end else if (enable) begin
         presc <= tick ? 16'd0 : presc + 16'd1;
      end
   end

   // Base hue advances once per tick, wrapping naturally at 8 bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_hue <= 8'd0;
      end else if (tick) begin
         base_hue <= base_hue + 8'd1;
      end
   end

   // One-deep frame request latch; a tick while a request waits is dropped
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (start) begin
         pending <= 1'b0;
      end else if (tick) begin
         pending <= 1'b1;
      end
   end

   // Frame FSM: LOAD drives the converter, CAPT samples its result.
   // hue_acc steps by spread per LED, equal to base + idx*spread mod 256.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         idx        <= '0;
         sat_sh     <= 8'h00;
         val_sh     <= 8'h00;
         spread_sh  <= 8'h00;
         hue_acc    <= 8'h00;
         hsv_h      <= 8'h00;
         hsv_s      <= 8'h00;
         hsv_v      <= 8'h00;
         led_idx    <= '0;
         led_rgb    <= 24'h0;
         led_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         led_valid  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_LOAD;
                  idx       <= '0;
                  sat_sh    <= sat;
                  val_sh    <= val;
                  spread_sh <= spread;
                  // base_hue increments on this same edge when tick fires
                  hue_acc   <= tick ? base_hue + 8'd1 : base_hue;
               end
            end
            S_LOAD: begin
               hsv_h <= hue_acc;
               hsv_s <= sat_sh;
               hsv_v <= val_sh;
               state <= S_CAPT;
            end
            S_CAPT: begin
               led_rgb   <= {rgb_r, rgb_g, rgb_b};
               led_idx   <= idx;
               led_valid <= 1'b1;
               if (idx == LAST_IDX) begin
                  frame_done <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  idx     <= idx + IDX_W'(1);
                  hue_acc <= hue_acc + spread_sh;
                  state   <= S_LOAD;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
